// File: rtl/pdp8_rf_brk_pkg.sv
// pdp8_rf_brk_pkg: state encoding, register addresses and the
// shared 12-bit incrementer used by the data-break engine.
package pdp8_rf_brk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_WC_RD = 3'd2,
    ST_WC_WR = 3'd3,
    ST_CA_RD = 3'd4,
    ST_CA_WR = 3'd5,
    ST_DATA  = 3'd6,
    ST_DONE  = 3'd7
  } brk_state_e;

  localparam logic [11:0] WC_ADDR_DEF = 12'o7750;
  localparam logic [11:0] CA_ADDR_DEF = 12'o7751;

  // 12-bit wrap: 7777 -> 0000
  function automatic logic [11:0] inc12(input logic [11:0] v);
    return v + 12'd1;
  endfunction

endpackage

// File: rtl/pdp8_rf_brk.sv
// pdp8_rf_brk: RF08 three-cycle data-break engine (WC, CA, data).
// Ports: brk_* handshake to RF, brk_mreq/brk_grant to the CPU
// arbiter, ram_* strobe/done interface to core memory.
import pdp8_rf_brk_pkg::*;

module pdp8_rf_brk #(
  parameter logic [11:0] WC_ADDR = WC_ADDR_DEF,
  parameter logic [11:0] CA_ADDR = CA_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        brk_req,
  input  logic        brk_wr,
  input  logic [2:0]  brk_ema,
  input  logic [11:0] brk_wdata,
  output logic        brk_ack,
  output logic [11:0] brk_rdata,
  output logic        brk_wc_ovf,
  output logic        brk_busy,
  output logic        brk_mreq,
  input  logic        brk_grant,
  output logic [14:0] ram_addr,
  output logic [11:0] ram_wdata,
  output logic        ram_rd,
  output logic        ram_wr,
  input  logic [11:0] ram_rdata,
  input  logic        ram_done
);

  brk_state_e  state_q, state_d;
  logic        wr_q, wr_d;
  logic [2:0]  ema_q, ema_d;
  logic [11:0] wdata_q, wdata_d;
  logic [11:0] ca_q, ca_d;
  logic        ovf_q, ovf_d;
  logic        ack_q, ack_d;
  logic        wc_ovf_q, wc_ovf_d;
  logic [11:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        mreq_q, mreq_d;
  logic [14:0] addr_q, addr_d;
  logic [11:0] mwd_q, mwd_d;
  logic        rd_q, rd_d;
  logic        wstb_q, wstb_d;

  logic [11:0] inc;
  logic        strobe;
  logic        done;
  logic        mem_st;
  logic        cur_wr;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    ema_d    = ema_q;
    wdata_d  = wdata_q;
    ca_d     = ca_q;
    ovf_d    = ovf_q;
    ack_d    = 1'b0;
    wc_ovf_d = 1'b0;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    mreq_d   = mreq_q;
    addr_d   = addr_q;
    mwd_d    = mwd_q;
    rd_d     = rd_q;
    wstb_d   = wstb_q;

    inc    = inc12(ram_rdata);
    strobe = rd_q | wstb_q;
    done   = strobe & ram_done;
    mem_st = state_q inside {ST_WC_RD, ST_WC_WR,
                             ST_CA_RD, ST_CA_WR, ST_DATA};
    cur_wr = (state_q == ST_WC_WR) |
             (state_q == ST_CA_WR) |
             ((state_q == ST_DATA) & wr_q);

    // A memory state whose op has not been launched
    // (grant was lost) starts it once grant returns.
    if (mem_st && !strobe && brk_grant) begin
      rd_d   = ~cur_wr;
      wstb_d = cur_wr;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (brk_req) begin
          wr_d    = brk_wr;
          ema_d   = brk_ema;
          wdata_d = brk_wdata;
          mreq_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (brk_grant) begin
          addr_d  = {3'o0, WC_ADDR};
          rd_d    = 1'b1;
          state_d = ST_WC_RD;
        end
      end
      ST_WC_RD: begin
        if (done) begin
          ovf_d   = (inc == 12'o0);
          mwd_d   = inc;
          rd_d    = 1'b0;
          wstb_d  = brk_grant;
          state_d = ST_WC_WR;
        end
      end
      ST_WC_WR: begin
        if (done) begin
          addr_d  = {3'o0, CA_ADDR};
          wstb_d  = 1'b0;
          rd_d    = brk_grant;
          state_d = ST_CA_RD;
        end
      end
      ST_CA_RD: begin
        if (done) begin
          ca_d    = inc;
          mwd_d   = inc;
          rd_d    = 1'b0;
          wstb_d  = brk_grant;
          state_d = ST_CA_WR;
        end
      end
      ST_CA_WR: begin
        if (done) begin
          // CA wrap stays inside the EMA field.
          addr_d  = {ema_q, ca_q};
          mwd_d   = wdata_q;
          rd_d    = brk_grant & ~wr_q;
          wstb_d  = brk_grant & wr_q;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (done) begin
          if (!wr_q) rdata_d = ram_rdata;
          rd_d     = 1'b0;
          wstb_d   = 1'b0;
          ack_d    = 1'b1;
          wc_ovf_d = ovf_q;
          mreq_d   = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_q     <= 1'b0;
      ema_q    <= 3'o0;
      wdata_q  <= 12'o0;
      ca_q     <= 12'o0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      wc_ovf_q <= 1'b0;
      rdata_q  <= 12'o0;
      busy_q   <= 1'b0;
      mreq_q   <= 1'b0;
      addr_q   <= 15'o0;
      mwd_q    <= 12'o0;
      rd_q     <= 1'b0;
      wstb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      ema_q    <= ema_d;
      wdata_q  <= wdata_d;
      ca_q     <= ca_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
      wc_ovf_q <= wc_ovf_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      mreq_q   <= mreq_d;
      addr_q   <= addr_d;
      mwd_q    <= mwd_d;
      rd_q     <= rd_d;
      wstb_q   <= wstb_d;
    end
  end

  assign brk_ack    = ack_q;
  assign brk_rdata  = rdata_q;
  assign brk_wc_ovf = wc_ovf_q;
  assign brk_busy   = busy_q;
  assign brk_mreq   = mreq_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = mwd_q;
  assign ram_rd     = rd_q;
  assign ram_wr     = wstb_q;

endmodule

// File: tb/tb_pdp8_rf_brk.sv
// tb_pdp8_rf_brk: self-checking bench for the RF08 data-break
// engine with a core model, an arbiter model and a reference model.
module tb_pdp8_rf_brk;

  localparam logic [14:0] WCA = 15'o07750;
  localparam logic [14:0] CAA = 15'o07751;

  logic        clk = 1'b0;
  logic        rst;
  logic        brk_req, brk_wr;
  logic [2:0]  brk_ema;
  logic [11:0] brk_wdata;
  logic        brk_ack, brk_wc_ovf, brk_busy, brk_mreq;
  logic [11:0] brk_rdata;
  logic        brk_grant;
  logic [14:0] ram_addr;
  logic [11:0] ram_wdata, ram_rdata;
  logic        ram_rd, ram_wr, ram_done;

  int n_chk = 0;
  int n_fail = 0;

  int   gmode;
  logic man_grant;
  logic rnd_grant = 1'b1;
  int   mem_delay;

  logic [11:0] mem     [0:32767];
  logic [11:0] ref_mem [0:32767];
  logic [11:0] rd_hold;

  logic        pl_req;
  logic [14:0] pl_addr;
  logic [11:0] pl_data;

  int wr_cnt = 0;
  int ack_total = 0;
  int proto_err = 0;

  always #5 clk = ~clk;

  assign brk_grant = (gmode == 0) ? brk_mreq :
                     (gmode == 1) ? man_grant :
                     (brk_mreq & rnd_grant);

  always @(negedge clk) rnd_grant <= ($urandom_range(0, 3) != 0);

  pdp8_rf_brk dut (
    .clk        (clk),
    .reset      (rst),
    .brk_req    (brk_req),
    .brk_wr     (brk_wr),
    .brk_ema    (brk_ema),
    .brk_wdata  (brk_wdata),
    .brk_ack    (brk_ack),
    .brk_rdata  (brk_rdata),
    .brk_wc_ovf (brk_wc_ovf),
    .brk_busy   (brk_busy),
    .brk_mreq   (brk_mreq),
    .brk_grant  (brk_grant),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rd     (ram_rd),
    .ram_wr     (ram_wr),
    .ram_rdata  (ram_rdata),
    .ram_done   (ram_done)
  );

  // Core memory: done follows mem_delay idle cycles of strobe.
  int cnt = 0;
  always @(posedge clk) begin
    if (pl_req) mem[pl_addr] <= pl_data;
    if (rst) begin
      ram_done <= 1'b0;
      cnt <= 0;
    end else if (ram_done) begin
      ram_done <= 1'b0;
      cnt <= 0;
    end else if (ram_rd || ram_wr) begin
      if (cnt >= mem_delay) begin
        ram_done <= 1'b1;
        cnt <= 0;
        if (ram_wr) begin
          mem[ram_addr] <= ram_wdata;
          wr_cnt <= wr_cnt + 1;
        end else begin
          ram_rdata <= mem[ram_addr];
        end
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  // Protocol monitor.
  logic        l_stb = 1'b0, l_done = 1'b0, l_grant = 1'b0;
  logic        l_rd = 1'b0, l_ack = 1'b0;
  logic [14:0] l_addr;
  logic [11:0] l_wd;
  always @(posedge clk) begin : mon
    int e;
    e = 0;
    if (!rst) begin
      if (ram_rd && ram_wr) e++;
      if (brk_ack && l_ack) e++;
      if ((ram_rd || ram_wr) && l_stb && !l_done)
        if (ram_addr !== l_addr || ram_rd !== l_rd ||
            (ram_wr && ram_wdata !== l_wd)) e++;
      if ((ram_rd || ram_wr) && !l_stb && !l_grant) e++;
      if (brk_ack) ack_total <= ack_total + 1;
    end
    proto_err <= proto_err + e;
    l_stb   <= rst ? 1'b0 : (ram_rd | ram_wr);
    l_done  <= ram_done;
    l_grant <= brk_grant;
    l_rd    <= ram_rd;
    l_addr  <= ram_addr;
    l_wd    <= ram_wdata;
    l_ack   <= rst ? 1'b0 : brk_ack;
  end

  task automatic poke(input logic [14:0] a, input logic [11:0] d);
    pl_addr = a;
    pl_data = d;
    pl_req  = 1'b1;
    @(posedge clk); #1;
    pl_req  = 1'b0;
    ref_mem[a] = d;
  endtask

  // RF side: hold request until ack, drop it the cycle after.
  task automatic run_break(input logic wr, input logic [2:0] ema,
                           input logic [11:0] wd,
                           output logic [11:0] rd, output logic ovf,
                           output int nc, output logic ack2);
    nc = -1;
    rd = '0;
    ovf = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 200 && brk_busy; i++) begin
      @(posedge clk); #1;
    end
    brk_req = 1'b1;
    brk_wr = wr;
    brk_ema = ema;
    brk_wdata = wd;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk); #1;
      brk_wdata = 12'($urandom);
      brk_ema = 3'($urandom);
      if (brk_ack) begin
        nc = i;
        rd = brk_rdata;
        ovf = brk_wc_ovf;
        break;
      end
    end
    @(posedge clk); #1;
    ack2 = brk_ack;
    brk_req = 1'b0;
    brk_wr = 1'($urandom);
  endtask

  // Reference: WC++, CA++, then one word at {ema, CA}.
  task automatic model_break(input logic wr, input logic [2:0] ema,
                             input logic [11:0] wd,
                             output logic [11:0] erd,
                             output logic eovf,
                             output logic [14:0] da);
    int wc, ca;
    wc = (int'(ref_mem[WCA]) + 1) % 4096;
    ref_mem[WCA] = 12'(wc);
    ca = (int'(ref_mem[CAA]) + 1) % 4096;
    ref_mem[CAA] = 12'(ca);
    da = 15'(int'(ema) * 4096 + ca);
    if (wr) ref_mem[da] = wd;
    else rd_hold = ref_mem[da];
    erd = rd_hold;
    eovf = (wc == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({brk_ack, brk_wc_ovf, brk_busy, brk_mreq, ram_rd, ram_wr} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 000000",
               {brk_ack, brk_wc_ovf, brk_busy, brk_mreq, ram_rd, ram_wr});
    end
    n_chk++;
    if ({brk_rdata, ram_addr, ram_wdata} !== 39'b0) begin
      n_fail++;
      $display("FAIL reset_data got %o %o %o want 0 0 0",
               brk_rdata, ram_addr, ram_wdata);
    end
    rst = 1'b0;
    rd_hold = 12'o0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (brk_busy !== 1'b0 || brk_mreq !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_quiet got busy=%b mreq=%b want 0 0",
               brk_busy, brk_mreq);
    end
  endtask

  task automatic test_write_break(input int dly, input string tag);
    logic [11:0] rd;
    logic ovf, ack2;
    int nc, a0, w0, p0;
    gmode = 0;
    mem_delay = dly;
    poke(WCA, 12'o7775);
    poke(CAA, 12'o0377);
    poke(15'o20400, 12'o0);
    a0 = ack_total;
    w0 = wr_cnt;
    p0 = proto_err;
    run_break(1'b1, 3'd2, 12'o1234, rd, ovf, nc, ack2);
    @(posedge clk); #1;
    n_chk++;
    if (nc < 0) begin
      n_fail++;
      $display("FAIL %s_timeout got no ack want ack", tag);
    end
    n_chk++;
    if (mem[WCA] !== 12'o7776) begin
      n_fail++;
      $display("FAIL %s_wc got %o want 7776", tag, mem[WCA]);
    end
    n_chk++;
    if (mem[CAA] !== 12'o0400) begin
      n_fail++;
      $display("FAIL %s_ca got %o want 0400", tag, mem[CAA]);
    end
    n_chk++;
    if (mem[15'o20400] !== 12'o1234) begin
      n_fail++;
      $display("FAIL %s_data got %o want 1234", tag, mem[15'o20400]);
    end
    n_chk++;
    if (ovf !== 1'b0 || ack2 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ovf_ack got ovf=%b ack2=%b want 0 0", tag, ovf, ack2);
    end
    n_chk++;
    if (ack_total - a0 != 1 || wr_cnt - w0 != 3) begin
      n_fail++;
      $display("FAIL %s_counts got acks=%0d writes=%0d want 1 3",
               tag, ack_total - a0, wr_cnt - w0);
    end
    n_chk++;
    if (proto_err != p0) begin
      n_fail++;
      $display("FAIL %s_protocol got %0d errors want 0", tag, proto_err - p0);
    end
  endtask

  task automatic test_read_wrap();
    logic [11:0] rd;
    logic ovf, ack2;
    int nc;
    gmode = 0;
    mem_delay = 0;
    poke(WCA, 12'o7777);
    poke(CAA, 12'o7777);
    poke(15'o10000, 12'o4321);
    run_break(1'b0, 3'd1, 12'o0, rd, ovf, nc, ack2);
    n_chk++;
    if (mem[WCA] !== 12'o0000 || mem[CAA] !== 12'o0000) begin
      n_fail++;
      $display("FAIL rdwrap_regs got wc=%o ca=%o want 0000 0000",
               mem[WCA], mem[CAA]);
    end
    n_chk++;
    if (rd !== 12'o4321) begin
      n_fail++;
      $display("FAIL rdwrap_rdata got %o want 4321", rd);
    end
    n_chk++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL rdwrap_ovf got %b want 1", ovf);
    end
    rd_hold = 12'o4321;
  endtask

  task automatic test_grant_latency();
    int stb, bad, nc;
    logic [11:0] rd;
    gmode = 1;
    man_grant = 1'b0;
    mem_delay = 0;
    poke(WCA, 12'o0010);
    poke(CAA, 12'o1000);
    poke(15'o01001, 12'o6543);
    brk_req = 1'b1;
    brk_wr = 1'b0;
    brk_ema = 3'd0;
    stb = 0;
    bad = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ram_rd || ram_wr) stb++;
      if (!brk_busy || !brk_mreq) bad++;
    end
    n_chk++;
    if (stb != 0 || bad != 0) begin
      n_fail++;
      $display("FAIL nogrant got strobes=%0d notbusy=%0d want 0 0", stb, bad);
    end
    man_grant = 1'b1;
    nc = -1;
    rd = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (brk_ack) begin
        nc = i;
        rd = brk_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    brk_req = 1'b0;
    man_grant = 1'b0;
    n_chk++;
    if (nc != 11) begin
      n_fail++;
      $display("FAIL latency got %0d want 11", nc);
    end
    n_chk++;
    if (rd !== 12'o6543 || mem[WCA] !== 12'o0011 || mem[CAA] !== 12'o1001) begin
      n_fail++;
      $display("FAIL latency_result got rd=%o wc=%o ca=%o want 6543 0011 1001",
               rd, mem[WCA], mem[CAA]);
    end
    rd_hold = 12'o6543;
  endtask

  task automatic test_reset_mid();
    logic [11:0] rd, erd;
    logic ovf, ack2, eovf, found;
    logic [14:0] da;
    int nc;
    gmode = 0;
    mem_delay = 0;
    poke(WCA, 12'o0100);
    poke(CAA, 12'o0200);
    poke(15'o30201, 12'o7070);
    @(posedge clk); #1;
    brk_req = 1'b1;
    brk_wr = 1'b1;
    brk_ema = 3'd3;
    brk_wdata = 12'o5555;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (ram_wr && ram_addr == CAA) begin
        found = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL rstmid_reach got no CA write want CA write");
    end
    n_chk++;
    if ({brk_ack, brk_wc_ovf, brk_busy, brk_mreq, ram_rd, ram_wr,
         brk_rdata, ram_addr, ram_wdata} !== 45'b0) begin
      n_fail++;
      $display("FAIL rstmid_outs got busy=%b mreq=%b rd=%b wr=%b addr=%o want all 0",
               brk_busy, brk_mreq, ram_rd, ram_wr, ram_addr);
    end
    brk_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd_hold = 12'o0;
    n_chk++;
    if (mem[WCA] !== 12'o0101 || mem[CAA] !== 12'o0200 ||
        mem[15'o30201] !== 12'o7070) begin
      n_fail++;
      $display("FAIL rstmid_mem got wc=%o ca=%o d=%o want 0101 0200 7070",
               mem[WCA], mem[CAA], mem[15'o30201]);
    end
    ref_mem[WCA] = 12'o0101;
    model_break(1'b1, 3'd3, 12'o2222, erd, eovf, da);
    run_break(1'b1, 3'd3, 12'o2222, rd, ovf, nc, ack2);
    n_chk++;
    if (nc < 0 || mem[WCA] !== 12'o0102 || mem[CAA] !== 12'o0201 ||
        mem[15'o30201] !== 12'o2222 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_rerun got nc=%0d wc=%o ca=%o d=%o ovf=%b want wc=0102 ca=0201 d=2222 ovf=0",
               nc, mem[WCA], mem[CAA], mem[15'o30201], ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] rd;
    logic ovf, ack2, last_ovf;
    int nc, a0, novf, tmo;
    gmode = 0;
    mem_delay = 0;
    poke(WCA, 12'o7700);
    poke(CAA, 12'o2000);
    a0 = ack_total;
    novf = 0;
    tmo = 0;
    last_ovf = 1'b0;
    for (int i = 0; i < 64; i++) begin
      run_break(1'b1, 3'd4, 12'(i * 3 + 1), rd, ovf, nc, ack2);
      if (ovf) novf++;
      if (nc < 0) tmo++;
      if (i == 63) last_ovf = ovf;
    end
    @(posedge clk); #1;
    n_chk++;
    if (ack_total - a0 != 64 || tmo != 0) begin
      n_fail++;
      $display("FAIL b2b_acks got %0d timeouts=%0d want 64 0",
               ack_total - a0, tmo);
    end
    n_chk++;
    if (novf != 1 || last_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ovf got count=%0d last=%b want 1 1", novf, last_ovf);
    end
    n_chk++;
    if (mem[WCA] !== 12'o0000 || mem[CAA] !== 12'o2100) begin
      n_fail++;
      $display("FAIL b2b_regs got wc=%o ca=%o want 0000 2100",
               mem[WCA], mem[CAA]);
    end
    for (int i = 0; i < 64; i++) begin
      n_chk++;
      if (mem[15'o42001 + 15'(i)] !== 12'(i * 3 + 1)) begin
        n_fail++;
        $display("FAIL b2b_data[%0d] got %o want %o", i,
                 mem[15'o42001 + 15'(i)], 12'(i * 3 + 1));
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] rd, erd, wd;
    logic ovf, ack2, eovf, wr;
    logic [2:0] ema;
    logic [14:0] da;
    int nc, nca, p0;
    gmode = 2;
    p0 = proto_err;
    poke(WCA, 12'o7760);
    poke(CAA, 12'o7770);
    for (int i = 0; i < 30; i++) begin
      mem_delay = $urandom_range(0, 3);
      wr = 1'($urandom);
      ema = 3'($urandom_range(1, 7));
      wd = 12'($urandom);
      if (!wr) begin
        nca = (int'(ref_mem[CAA]) + 1) % 4096;
        poke(15'(int'(ema) * 4096 + nca), 12'($urandom));
      end
      model_break(wr, ema, wd, erd, eovf, da);
      run_break(wr, ema, wd, rd, ovf, nc, ack2);
      n_chk++;
      if (nc < 0 || rd !== erd || ovf !== eovf) begin
        n_fail++;
        $display("FAIL rnd%0d_ack got nc=%0d rd=%o ovf=%b want rd=%o ovf=%b",
                 i, nc, rd, ovf, erd, eovf);
      end
      n_chk++;
      if (mem[WCA] !== ref_mem[WCA] || mem[CAA] !== ref_mem[CAA] ||
          mem[da] !== ref_mem[da]) begin
        n_fail++;
        $display("FAIL rnd%0d_mem got wc=%o ca=%o d=%o want %o %o %o", i,
                 mem[WCA], mem[CAA], mem[da],
                 ref_mem[WCA], ref_mem[CAA], ref_mem[da]);
      end
    end
    n_chk++;
    if (proto_err != p0) begin
      n_fail++;
      $display("FAIL rnd_protocol got %0d errors want 0", proto_err - p0);
    end
  endtask

  initial begin
    rst = 1'b1;
    brk_req = 1'b0;
    brk_wr = 1'b0;
    brk_ema = 3'd0;
    brk_wdata = 12'o0;
    pl_req = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    gmode = 0;
    man_grant = 1'b0;
    mem_delay = 0;
    rd_hold = 12'o0;
    test_reset();
    test_write_break(0, "wr");
    test_read_wrap();
    test_grant_latency();
    test_write_break(3, "slow");
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_chk++;
    if (proto_err != 0) begin
      n_fail++;
      $display("FAIL protocol got %0d errors want 0", proto_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
